// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/DMA RAM arbiter: FSM states, requester IDs, default widths.
package mem_arb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DEPTH  = 256;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Port IDs double as the bit index into the arbiter request vector.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: on a tie the port that did not win last time is granted.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,   // indexed by port ID
  input  logic       load_i,  // commit the current grant as last_grant
  output logic       grant_o, // winning port ID, meaningful only when |req_i
  output logic       last_grant_o
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    case (req_i)
      2'b01:   grant_o = PORT_CPU;
      2'b10:   grant_o = PORT_DMA;
      2'b11:   grant_o = ~last_grant_q;
      default: grant_o = PORT_CPU;
    endcase
    last_grant_d = load_i ? grant_o : last_grant_q;
  end

  // DMA as the reset owner makes the CPU win the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= PORT_DMA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between CPU and DMA; each access runs SETUP -> ACCESS -> DONE.
// Define MEM_ARB_RANGE_CHECK_EN to block accesses at or above DEPTH and flag them on *_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              dma_err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic arb_grant;
  logic arb_load;
  logic unused_last_grant;
  logic oor;
  logic drive_en;

`ifdef MEM_ARB_RANGE_CHECK_EN
  assign oor = (32'(addr_q) >= DEPTH);
`else
  logic unused_depth;
  assign oor          = 1'b0;
  assign unused_depth = (DEPTH == 0);
`endif

  rr_arbiter2 u_arb (
    .clk_i        (clock),
    .rst_i        (clear),
    .req_i        ({dma_req, cpu_req}),
    .load_i       (arb_load),
    .grant_o      (arb_grant),
    .last_grant_o (unused_last_grant)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    arb_load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          arb_load = 1'b1;
          grant_d  = arb_grant;
          we_d     = (arb_grant == PORT_DMA) ? dma_we    : cpu_we;
          addr_d   = (arb_grant == PORT_DMA) ? dma_addr  : cpu_addr;
          wdata_d  = (arb_grant == PORT_DMA) ? dma_wdata : cpu_wdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        state_d = ST_DONE;
        // A blocked read leaves the requester's rdata untouched.
        if (!we_q && !oor) begin
          if (grant_q == PORT_CPU) begin
            cpu_rdata_d = ram_data;
          end else begin
            dma_rdata_d = ram_data;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      grant_q     <= PORT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign ram_addr  = addr_q;
  assign ram_read  = (state_q == ST_ACCESS) && !we_q && !oor;
  assign ram_write = (state_q == ST_ACCESS) && we_q && !oor;

  // Write data is held from SETUP through DONE so the level-sensitive RAM sees it stable.
  assign drive_en = busy && we_q && !oor;
  assign ram_data = drive_en ? wdata_q : {DATA_W{1'bz}};

  assign cpu_done  = (state_q == ST_DONE) && (grant_q == PORT_CPU);
  assign dma_done  = (state_q == ST_DONE) && (grant_q == PORT_DMA);
  assign cpu_err   = cpu_done && oor;
  assign dma_err   = dma_done && oor;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule
